// File: rtl/gauss_ctrl_pkg.sv
// Shared types and constants for the 3x3 Gaussian frame sequencer.
package gauss_ctrl_pkg;

  localparam int unsigned CwDefault = 11;

  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StFlush
  } ctrl_state_e;

  // Bit positions inside the {top, bottom, left, right} border vector.
  localparam int unsigned BorderTop   = 3;
  localparam int unsigned BorderBot   = 2;
  localparam int unsigned BorderLeft  = 1;
  localparam int unsigned BorderRight = 0;

endpackage

// File: rtl/frame_pos_cnt.sv
// Column/row position counter: column wraps at COL_NUM-1 and carries into the row.
module frame_pos_cnt #(
  parameter int unsigned COL_NUM = 4,
  parameter int unsigned CW      = 11
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en_i,
  input  logic          clr_i,
  output logic [CW-1:0] col_o,
  output logic [CW-1:0] row_o
);

  localparam logic [CW-1:0] LastCol = CW'(COL_NUM - 1);

  logic [CW-1:0] col_d, col_q;
  logic [CW-1:0] row_d, row_q;

  // Clear has priority over a simultaneous advance.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clr_i) begin
      col_d = '0;
      row_d = '0;
    end else if (en_i) begin
      if (col_q == LastCol) begin
        col_d = '0;
        row_d = row_q + CW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign col_o = col_q;
  assign row_o = row_q;

endmodule

// File: rtl/gauss_frame_ctrl.sv
// Frame sequencer: gates pixels into the window matrix, appends a zero flush row,
// and reports window centre coordinates, border flags and frame completion.
module gauss_frame_ctrl
  import gauss_ctrl_pkg::*;
#(
  parameter int unsigned COL_NUM = 4,
  parameter int unsigned ROW_NUM = 5,
  parameter int unsigned CW      = CwDefault
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic          pix_valid,
  output logic          pix_ready,
  output logic          mat_valid,
  output logic          mat_zero,
  output logic          win_valid,
  output logic [CW-1:0] win_row,
  output logic [CW-1:0] win_col,
  output logic [3:0]    border,
  output logic          busy,
  output logic          done
);

  localparam longint unsigned CntMax = (64'd1 << CW) - 64'd1;

  if (COL_NUM < 2 || ROW_NUM < 2 || longint'(ROW_NUM + 1) > CntMax ||
      longint'(COL_NUM) > CntMax) begin : g_bad_params
    $error("gauss_frame_ctrl: COL_NUM/ROW_NUM must be >= 2 and fit in CW bits");
  end

  localparam logic [CW-1:0] LastCol = CW'(COL_NUM - 1);
  localparam logic [CW-1:0] LastRow = CW'(ROW_NUM - 1);

  ctrl_state_e   state_d, state_q;
  logic          beat, last_col, flush_end, cnt_clr;
  logic [CW-1:0] in_col, in_row;

  logic          win_valid_d, win_valid_q;
  logic [CW-1:0] win_row_d, win_row_q;
  logic [CW-1:0] win_col_d, win_col_q;
  logic [3:0]    border_d, border_q;
  logic          busy_d, busy_q;
  logic          done_d, done_q;

  assign pix_ready = (state_q == StFill);
  assign mat_zero  = (state_q == StFlush);
  assign mat_valid = (pix_ready & pix_valid) | mat_zero;
  assign beat      = mat_valid;
  assign last_col  = (in_col == LastCol);
  assign flush_end = mat_zero & last_col;
  // Counters return to zero at the end of the flush row so IDLE always sees (0,0).
  assign cnt_clr   = abort | flush_end;

  frame_pos_cnt #(
    .COL_NUM (COL_NUM),
    .CW      (CW)
  ) u_pos_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (beat),
    .clr_i (cnt_clr),
    .col_o (in_col),
    .row_o (in_row)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start && !abort) state_d = StFill;
      end
      StFill: begin
        if (abort) begin
          state_d = StIdle;
        end else if (beat && last_col && (in_row == LastRow)) begin
          state_d = StFlush;
        end
      end
      StFlush: begin
        if (abort || last_col) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    win_valid_d = beat & (in_row != '0) & ~abort;
    win_row_d   = win_row_q;
    win_col_d   = win_col_q;
    border_d    = border_q;
    if (win_valid_d) begin
      win_row_d              = in_row - CW'(1);
      win_col_d              = in_col;
      border_d[BorderTop]    = (win_row_d == '0);
      border_d[BorderBot]    = (win_row_d == LastRow);
      border_d[BorderLeft]   = (win_col_d == '0);
      border_d[BorderRight]  = (win_col_d == LastCol);
    end
    done_d = win_valid_d & (win_row_d == LastRow) & (win_col_d == LastCol);
    busy_d = (state_d != StIdle) | done_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      win_valid_q <= 1'b0;
      win_row_q   <= '0;
      win_col_q   <= '0;
      border_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      win_valid_q <= win_valid_d;
      win_row_q   <= win_row_d;
      win_col_q   <= win_col_d;
      border_q    <= border_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign win_valid = win_valid_q;
  assign win_row   = win_row_q;
  assign win_col   = win_col_q;
  assign border    = border_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: doc/gauss_frame_ctrl.md
Name: gauss_frame_ctrl

Overview:
Frame sequencer for the 3x3 Gaussian window datapath (line buffers plus window matrix). It accepts one frame per start command and gates the upstream pixel stream into the matrix. It then injects one trailing row of zero pixels to flush the last image row out of the line buffers. For every window it emits the centre coordinates, border flags and a frame-done pulse, which downstream kernel logic uses to select padding.

Parameters:
COL_NUM, 4, pixels per row; must be >= 2.
ROW_NUM, 5, rows per frame; must be >= 2.
CW, 11, width of the row and column counters and coordinate outputs.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  single-cycle frame start command.
abort  in  1  synchronous frame abort.
pix_valid  in  1  upstream pixel valid.
pix_ready  out  1  controller accepts a pixel this cycle.
mat_valid  out  1  valid_in to the matrix/line-buffer chain.
mat_zero  out  1  forces the matrix din to 0 (flush row).
win_valid  out  1  window output valid.
win_row  out  CW  row of the window centre.
win_col  out  CW  column of the window centre.
border  out  4  {top, bottom, left, right} flags for the current window.
busy  out  1  frame in progress.
done  out  1  single-cycle pulse marking frame completion.

Behaviour:
- Clock and reset: one clock, clk; asynchronous active-low reset, rst_n.
- Reset values: all outputs 0, state IDLE, in_row = 0, in_col = 0.
- States:
  - IDLE: start moves to FILL on the next cycle.
  - FILL: moves to FLUSH after the beat at in_row = ROW_NUM-1, in_col = COL_NUM-1 is accepted.
  - FLUSH: moves to IDLE after the beat at in_col = COL_NUM-1.
- Combinational decodes:
  - pix_ready = (state == FILL).
  - mat_valid = (FILL & pix_valid) | FLUSH.
  - mat_zero = (state == FLUSH).
- Beats: a beat is any cycle with mat_valid = 1.
  - Each beat advances in_col. At COL_NUM-1, in_col wraps to 0 and in_row increments.
  - Flush beats use in_row = ROW_NUM.
  - Gaps in pix_valid during FILL hold the counters. FLUSH never stalls and always issues COL_NUM consecutive beats.
- Window outputs are registered, 1-cycle latency:
  - win_valid <= beat & (in_row >= 1).
  - win_row <= in_row - 1; win_col <= in_col.
  - Coordinates hold their value when win_valid = 0.
- Border flags are registered with the window: top = (win_row == 0), bottom = (win_row == ROW_NUM-1), left = (win_col == 0), right = (win_col == COL_NUM-1).
- done: asserted in the same cycle as the window at (ROW_NUM-1, COL_NUM-1).
- busy: high from the cycle after start is accepted through the done cycle inclusive; 0 otherwise.
- Frame length: a gapless frame starting at cycle 0 runs FILL on cycles 1..R*C and FLUSH on cycles R*C+1..R*C+C; done is on cycle R*C+C+1.
- Boundary conditions:
  - start while not IDLE: ignored, with no restart and no counter change.
  - start in the same cycle as done: the new frame is accepted, since the state is already IDLE.
  - abort in FILL or FLUSH: next cycle state is IDLE and counters are 0. win_valid, busy and done are forced to 0 that cycle, and no done is issued for the aborted frame.
  - abort and start together in IDLE: abort wins and the frame is not started.
  - abort in IDLE: no effect.
  - Asynchronous reset mid-frame: the same clean return to IDLE, applied asynchronously.
  - pix_valid while IDLE or FLUSH: not accepted, pix_ready = 0, and the counters do not advance.
- Widths: counters are CW bits. ROW_NUM+1 and COL_NUM must fit in CW bits; an elaboration-time check enforces this and the >= 2 parameter limits.

Decomposition:
- Package gauss_ctrl_pkg holds:
  - the state encoding (IDLE, FILL, FLUSH);
  - the border bit indices (TOP = 3, BOT = 2, LEFT = 1, RIGHT = 0);
  - a default CW constant.
- One natural sub-module, frame_pos_cnt: the in_col/in_row wrap counter with enable and synchronous clear, reused by the window-matrix counters.

Test Plan:
1. Reset asserted mid-FILL (after 7 beats), COL_NUM = 4, ROW_NUM = 5 -> all outputs 0 immediately; after release, start gives a full frame with exactly 20 windows.
2. start at cycle 0, pix_valid held 1 -> pix_ready on cycles 1..20; mat_zero on cycles 21..24; first win_valid on cycle 6 with (0,0) and border = 4'b1010; done on cycle 25 with (4,3) and border = 4'b0101.
3. pix_valid toggles 1/0 each cycle in FILL -> counters hold during gaps; window sequence is identical to test 2; done on cycle 45.
4. start pulsed on cycle 10 mid-frame -> ignored; done count is 1 and timing is unchanged.
5. abort on cycle 22 (during FLUSH) -> IDLE at cycle 23, busy = 0, no done; a following start gives a complete frame from (0,0).
6. start on the done cycle -> a back-to-back frame begins the next cycle with pix_ready = 1; the scoreboard sees 40 windows and 2 done pulses.
